ysyx_220066_mem_arb: RTL and testbench

Two-requester arbiter and sequencer for the single shared 64-bit memory port of the ysyx_220066 core. It sits between the instruction-fetch stage, the M (memory) stage, and the external memory bus, and serialises their accesses with one outstanding transaction. It formats store data and byte masks, and extracts and extends load data. It drives the M stage's `block` input through `mem_busy`.

---
 rtl/ysyx_220066_pkg.sv | 27 ++
 rtl/ysyx_220066_lsu_fmt.sv | 52 +++++
 rtl/ysyx_220066_mem_arb.sv | 157 +++++++++++++++
 tb/tb_ysyx_220066_mem_arb.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_220066_pkg.sv
// Shared constants and types for the ysyx_220066 memory arbiter and LSU formatter.
package ysyx_220066_pkg;

    localparam int XLEN = 64;

    localparam logic [1:0] MEMOP_SIZE_B = 2'd0;
    localparam logic [1:0] MEMOP_SIZE_H = 2'd1;
    localparam logic [1:0] MEMOP_SIZE_W = 2'd2;
    localparam logic [1:0] MEMOP_SIZE_D = 2'd3;
    localparam int         MEMOP_ZEXT_BIT = 2;

    // Instruction fetches are formatted as zero-extended word loads.
    localparam logic [2:0] MEMOP_IFETCH = {1'b1, MEMOP_SIZE_W};

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CMD  = 2'd1,
        ARB_RSP  = 2'd2,
        ARB_ERR  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_MEM = 1'b1
    } owner_e;

endpackage

// File: rtl/ysyx_220066_lsu_fmt.sv
// Combinational store lane shift / byte mask, load extract / extend and
// misalignment detection for one memory operation.
module ysyx_220066_lsu_fmt
    import ysyx_220066_pkg::*;
(
    input  logic [2:0]      op,
    input  logic [2:0]      offset,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] wdata_lane,
    output logic [7:0]      wmask,
    output logic [XLEN-1:0] rdata_ext,
    output logic            misaligned
);

    logic [5:0]      bit_off;
    logic [XLEN-1:0] rdata_sh;
    logic            sext;

    assign bit_off    = {offset, 3'b000};
    assign wdata_lane = wdata << bit_off;
    assign rdata_sh   = rdata >> bit_off;
    assign sext       = ~op[MEMOP_ZEXT_BIT];

    always_comb begin
        wmask      = 8'h00;
        misaligned = 1'b0;
        rdata_ext  = rdata_sh;
        case (op[1:0])
            MEMOP_SIZE_B: begin
                wmask     = 8'h01 << offset;
                rdata_ext = {{56{sext & rdata_sh[7]}}, rdata_sh[7:0]};
            end
            MEMOP_SIZE_H: begin
                wmask      = 8'h03 << offset;
                misaligned = offset[0];
                rdata_ext  = {{48{sext & rdata_sh[15]}}, rdata_sh[15:0]};
            end
            MEMOP_SIZE_W: begin
                wmask      = 8'h0F << offset;
                misaligned = |offset[1:0];
                rdata_ext  = {{32{sext & rdata_sh[31]}}, rdata_sh[31:0]};
            end
            default: begin
                wmask      = 8'hFF;
                misaligned = |offset;
                rdata_ext  = rdata_sh;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_220066_mem_arb.sv
// Fetch / M-stage arbiter for the shared 64-bit memory port, one transaction outstanding.
// Define YSYX_220066_ARB_RR_EN for round-robin tie breaking; default is fixed MEM priority.
module ysyx_220066_mem_arb
    import ysyx_220066_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_rvalid,
    output logic [31:0]     if_rdata,
    output logic            if_err,
    input  logic            mem_rd,
    input  logic            mem_wr,
    input  logic [2:0]      mem_op,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_wdata,
    output logic            mem_busy,
    output logic            mem_rvalid,
    output logic [XLEN-1:0] mem_rdata,
    output logic            mem_err,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [7:0]      bus_wmask,
    input  logic            bus_gnt,
    input  logic            bus_rvalid,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_err
);

    arb_state_e      state;
    owner_e          owner;
    logic [2:0]      lat_offset;
    logic [2:0]      lat_op;

    logic            mem_any;
    logic            idle;
    logic            pick_mem;
    logic [XLEN-1:0] win_addr;
    logic [2:0]      win_op;
    logic            win_we;

    logic [2:0]      fmt_offset;
    logic [2:0]      fmt_op;
    logic [XLEN-1:0] fmt_wdata;
    logic [7:0]      fmt_wmask;
    logic [XLEN-1:0] fmt_rdata;
    logic            fmt_misaligned;

    logic            rsp_fire;
    logic            rsp_err;

    assign mem_any = mem_rd | mem_wr;
    assign idle    = (state == ARB_IDLE);

`ifdef YSYX_220066_ARB_RR_EN
    owner_e last_served;

    assign pick_mem = mem_any & (~if_req | (last_served == OWNER_IF));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_served <= OWNER_IF;
        end else if (idle && (mem_any || if_req)) begin
            last_served <= pick_mem ? OWNER_MEM : OWNER_IF;
        end
    end
`else
    assign pick_mem = mem_any;
`endif

    assign win_addr = pick_mem ? mem_addr : if_addr;
    assign win_op   = pick_mem ? mem_op : MEMOP_IFETCH;
    assign win_we   = pick_mem & mem_wr;

    // In IDLE the formatter sees the incoming winner (for misalignment and the
    // store lanes captured into bus_*); afterwards it sees the latched command.
    assign fmt_offset = idle ? win_addr[2:0] : lat_offset;
    assign fmt_op     = idle ? win_op : lat_op;

    ysyx_220066_lsu_fmt u_fmt (
        .op         (fmt_op),
        .offset     (fmt_offset),
        .wdata      (mem_wdata),
        .rdata      (bus_rdata),
        .wdata_lane (fmt_wdata),
        .wmask      (fmt_wmask),
        .rdata_ext  (fmt_rdata),
        .misaligned (fmt_misaligned)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB_IDLE;
            owner      <= OWNER_IF;
            lat_offset <= 3'd0;
            lat_op     <= 3'd0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_wmask  <= 8'h00;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (mem_any || if_req) begin
                        owner      <= pick_mem ? OWNER_MEM : OWNER_IF;
                        lat_offset <= win_addr[2:0];
                        lat_op     <= win_op;
                        if (fmt_misaligned) begin
                            state <= ARB_ERR;
                        end else begin
                            state     <= ARB_CMD;
                            bus_req   <= 1'b1;
                            bus_we    <= win_we;
                            bus_addr  <= {win_addr[XLEN-1:3], 3'b000};
                            bus_wdata <= win_we ? fmt_wdata : '0;
                            bus_wmask <= win_we ? fmt_wmask : 8'h00;
                        end
                    end
                end
                ARB_CMD: begin
                    if (bus_gnt) begin
                        state   <= ARB_RSP;
                        bus_req <= 1'b0;
                    end
                end
                ARB_RSP: begin
                    if (bus_rvalid) begin
                        state <= ARB_IDLE;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign rsp_fire = (state == ARB_ERR) | ((state == ARB_RSP) & bus_rvalid);
    assign rsp_err  = (state == ARB_ERR) | bus_err;

    assign mem_rvalid = rsp_fire & (owner == OWNER_MEM);
    assign if_rvalid  = rsp_fire & (owner == OWNER_IF);
    assign mem_err    = mem_rvalid & rsp_err;
    assign if_err     = if_rvalid & rsp_err;

    assign mem_rdata = (mem_rvalid & ~mem_err) ? fmt_rdata : '0;
    assign if_rdata  = (if_rvalid & ~if_err)
                     ? (lat_offset[2] ? bus_rdata[63:32] : bus_rdata[31:0])
                     : 32'd0;

    assign mem_busy = mem_any & ~mem_rvalid;

endmodule

// File: tb/tb_ysyx_220066_mem_arb.sv
// Self-checking bench for ysyx_220066_mem_arb: directed scenarios followed by
// randomized fetch/load/store traffic checked against a byte-level reference model.
module tb_ysyx_220066_mem_arb;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  mem_op;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_busy;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        mem_err;
    logic        bus_req;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wmask;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [63:0] bus_rdata;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

`ifdef YSYX_220066_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    bit          lastServedMem;
    logic [63:0] lastRdata;
    logic [63:0] lastBusAddr;
    logic [63:0] lastBusWdata;
    logic [7:0]  lastBusWmask;
    logic        lastMemRvalid;

    ysyx_220066_mem_arb dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .if_err     (if_err),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_op     (mem_op),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_busy   (mem_busy),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wmask  (bus_wmask),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: byte-level view of an access of (1 << size) bytes at addr.
    function automatic int accBytes(input logic [2:0] op);
        return 1 << op[1:0];
    endfunction

    function automatic int accOffset(input logic [63:0] addr);
        return int'(addr % 64'd8);
    endfunction

    function automatic bit modelMisaligned(input logic [2:0] op, input logic [63:0] addr);
        return (addr % 64'(accBytes(op))) != 64'd0;
    endfunction

    function automatic logic [7:0] modelMask(input logic [2:0] op, input logic [63:0] addr, input bit we);
        logic [7:0] m;
        int n;
        int off;
        n = accBytes(op);
        off = accOffset(addr);
        m = 8'h00;
        if (we)
            for (int i = 0; i < 8; i++)
                if (i >= off && i < off + n) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] modelWdata(input logic [63:0] addr, input logic [63:0] wdata);
        logic [63:0] r;
        int off;
        off = accOffset(addr);
        r = 64'd0;
        for (int i = 0; i < 8; i++)
            if (off + i < 8) r[8*(off+i) +: 8] = wdata[8*i +: 8];
        return r;
    endfunction

    function automatic logic [63:0] modelLoad(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] rdata);
        logic [63:0] v;
        int n;
        int off;
        n = accBytes(op);
        off = accOffset(addr);
        v = 64'd0;
        for (int i = 0; i < n; i++)
            if (off + i < 8) v[8*i +: 8] = rdata[8*(off+i) +: 8];
        if (!op[2] && v[8*n-1])
            for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic bit pickMem(input bit reqIf, input bit reqMem);
        if (RR_MODE && reqIf && reqMem) return !lastServedMem;
        return reqMem;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit isMem, input bit isWr, input logic [2:0] op,
                                 input logic [63:0] addr, input logic [63:0] wdata);
        if (isMem) begin
            mem_rd    = !isWr;
            mem_wr    = isWr;
            mem_op    = op;
            mem_addr  = addr;
            mem_wdata = wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = addr;
        end
    endtask

    // Entered at the falling edge of an IDLE cycle with requests driven; returns at
    // the falling edge of the following IDLE cycle with the owner's request dropped.
    task automatic serveOne(input bit isMem, input int gntDelay, input int rspDelay,
                            input logic [63:0] rdata, input bit err);
        logic [2:0]  op;
        logic [63:0] addr;
        bit          we;
        bit          mis;
        op   = isMem ? mem_op : 3'b110;
        addr = isMem ? mem_addr : if_addr;
        we   = isMem && mem_wr;
        mis  = modelMisaligned(op, addr);
        #1;
        checkOutput("idle_busy", 64'(mem_busy), 64'(mem_rd | mem_wr));
        checkOutput("idle_rvalid", 64'({if_rvalid, mem_rvalid}), 64'd0);
        @(negedge clk);
        #1;
        if (mis) begin
            checkOutput("mis_busreq", 64'(bus_req), 64'd0);
        end else begin
            lastBusAddr  = bus_addr;
            lastBusWdata = bus_wdata;
            lastBusWmask = bus_wmask;
            for (int c = 0; c <= gntDelay; c++) begin
                checkOutput("cmd_req_we", 64'({bus_req, bus_we}), 64'({1'b1, we}));
                checkOutput("cmd_addr", bus_addr, addr - (addr % 64'd8));
                checkOutput("cmd_wmask", 64'(bus_wmask), 64'(modelMask(op, addr, we)));
                checkOutput("cmd_wdata", bus_wdata, we ? modelWdata(addr, mem_wdata) : 64'd0);
                checkOutput("cmd_rvalid", 64'({if_rvalid, mem_rvalid}), 64'd0);
                checkOutput("cmd_busy", 64'(mem_busy), 64'(mem_rd | mem_wr));
                bus_gnt    = (c == gntDelay);
                bus_rvalid = bit'($urandom_range(0, 1));
                @(negedge clk);
                bus_gnt    = 1'b0;
                bus_rvalid = 1'b0;
                #1;
            end
            for (int c = 0; c < rspDelay; c++) begin
                bus_gnt = bit'($urandom_range(0, 1));
                #1;
                checkOutput("rsp_wait_req", 64'(bus_req), 64'd0);
                checkOutput("rsp_wait_rvalid", 64'({if_rvalid, mem_rvalid}), 64'd0);
                @(negedge clk);
                bus_gnt = 1'b0;
                #1;
            end
            bus_rvalid = 1'b1;
            bus_rdata  = rdata;
            bus_err    = err;
            #1;
        end
        checkOutput("rsp_rvalid", 64'({if_rvalid, mem_rvalid}), isMem ? 64'd1 : 64'd2);
        checkOutput("rsp_err", 64'(isMem ? mem_err : if_err), 64'(mis | err));
        checkOutput("rsp_busy", 64'(mem_busy), isMem ? 64'd0 : 64'(mem_rd | mem_wr));
        if (isMem) begin
            checkOutput("rsp_if_quiet", 64'(if_rdata), 64'd0);
            if (mis || err)
                checkOutput("rsp_err_rdata", mem_rdata, 64'd0);
            else if (!we)
                checkOutput("rsp_load_rdata", mem_rdata, modelLoad(op, addr, rdata));
        end else begin
            checkOutput("rsp_mem_quiet", mem_rdata, 64'd0);
            if (!mis && !err)
                checkOutput("rsp_fetch_rdata", 64'(if_rdata), modelLoad(op, addr, rdata));
        end
        lastRdata     = isMem ? mem_rdata : 64'(if_rdata);
        lastMemRvalid = mem_rvalid;
        if (isMem) begin
            mem_rd = 1'b0;
            mem_wr = 1'b0;
        end else begin
            if_req = 1'b0;
        end
        lastServedMem = isMem;
        @(negedge clk);
        bus_rvalid = 1'b0;
        bus_err    = 1'b0;
    endtask

    // Reset is pulled low while a load sits in CMD (inRsp=0) or in RSP with a response arriving.
    task automatic resetMidTxn(input bit inRsp);
        applyStimulus(1'b1, 1'b0, 3'b011, 64'h8000_0040, 64'd0);
        @(negedge clk);
        #1;
        checkOutput("rstmid_pre_req", 64'(bus_req), 64'd1);
        if (inRsp) begin
            bus_gnt = 1'b1;
            @(negedge clk);
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b1;
            bus_rdata  = 64'h0123_4567_89AB_CDEF;
        end
        rst = 1'b0;
        #1;
        checkOutput("rstmid_req", 64'(bus_req), 64'd0);
        checkOutput("rstmid_rvalid", 64'({if_rvalid, mem_rvalid}), 64'd0);
        checkOutput("rstmid_busy", 64'(mem_busy), 64'd1);
        mem_rd     = 1'b0;
        bus_rvalid = 1'b0;
        lastServedMem = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bit          ri;
        bit          rm;
        bit          wr;
        bit          first;
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] ia;

        rst = 1'b0;
        if_req = 1'b0;  if_addr = 64'd0;
        mem_rd = 1'b0;  mem_wr = 1'b0;  mem_op = 3'd0;
        mem_addr = 64'd0;  mem_wdata = 64'd0;
        bus_gnt = 1'b0;  bus_rvalid = 1'b0;  bus_rdata = 64'd0;  bus_err = 1'b0;
        lastServedMem = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_bus_req", 64'(bus_req), 64'd0);
        checkOutput("reset_bus_addr", bus_addr, 64'd0);
        checkOutput("reset_bus_wmask", 64'(bus_wmask), 64'd0);
        checkOutput("reset_rvalid", 64'({if_rvalid, mem_rvalid, if_err, mem_err}), 64'd0);
        checkOutput("reset_rdata", mem_rdata | 64'(if_rdata), 64'd0);
        checkOutput("reset_busy", 64'(mem_busy), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] fetch at 0x80000004");
        applyStimulus(1'b0, 1'b0, 3'b110, 64'h8000_0004, 64'd0);
        serveOne(1'b0, 0, 0, 64'h1111_2222_3333_4444, 1'b0);
        checkOutput("tp_fetch_rdata", lastRdata, 64'h1111_2222);
        checkOutput("tp_fetch_addr", lastBusAddr, 64'h8000_0000);
        checkOutput("tp_fetch_wmask", 64'(lastBusWmask), 64'd0);

        $display("[TB] simultaneous fetch and load");
        applyStimulus(1'b0, 1'b0, 3'b110, 64'h8000_0100, 64'd0);
        applyStimulus(1'b1, 1'b0, 3'b011, 64'h8000_0200, 64'd0);
        first = pickMem(1'b1, 1'b1);
        serveOne(first, 0, 0, 64'hCAFE_F00D_DEAD_BEEF, 1'b0);
        checkOutput("tp_tie1_mem_first", 64'(lastMemRvalid), 64'd1);
        if (first) applyStimulus(1'b1, 1'b0, 3'b011, 64'h8000_0208, 64'd0);
        else       applyStimulus(1'b0, 1'b0, 3'b110, 64'h8000_0104, 64'd0);
        first = pickMem(1'b1, 1'b1);
        serveOne(first, 1, 1, 64'h0BAD_C0DE_1234_5678, 1'b0);
        checkOutput("tp_tie2_owner", 64'(lastMemRvalid), RR_MODE ? 64'd0 : 64'd1);
        serveOne(!first, 0, 0, 64'h7777_6666_5555_4444, 1'b0);

        $display("[TB] byte store, halfword loads, misaligned word");
        applyStimulus(1'b1, 1'b1, 3'b000, 64'h8000_0013, 64'hAB);
        serveOne(1'b1, 2, 0, 64'd0, 1'b0);
        checkOutput("tp_store_addr", lastBusAddr, 64'h8000_0010);
        checkOutput("tp_store_wmask", 64'(lastBusWmask), 64'h08);
        checkOutput("tp_store_wdata", lastBusWdata, 64'hAB00_0000);
        applyStimulus(1'b1, 1'b0, 3'b001, 64'h8000_0006, 64'd0);
        serveOne(1'b1, 0, 0, 64'h8001_0000_0000_0000, 1'b0);
        checkOutput("tp_lh_signed", lastRdata, 64'hFFFF_FFFF_FFFF_8001);
        applyStimulus(1'b1, 1'b0, 3'b101, 64'h8000_0006, 64'd0);
        serveOne(1'b1, 0, 0, 64'h8001_0000_0000_0000, 1'b0);
        checkOutput("tp_lh_unsigned", lastRdata, 64'h8001);
        applyStimulus(1'b1, 1'b0, 3'b010, 64'h8000_0002, 64'd0);
        serveOne(1'b1, 0, 0, 64'd0, 1'b0);

        $display("[TB] long grant stall, bus error, reset mid-transaction");
        applyStimulus(1'b1, 1'b1, 3'b011, 64'h8000_0028, 64'h1122_3344_5566_7788);
        serveOne(1'b1, 5, 0, 64'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'b010, 64'h8000_0034, 64'd0);
        serveOne(1'b1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        resetMidTxn(1'b0);
        applyStimulus(1'b0, 1'b0, 3'b110, 64'h8000_0008, 64'd0);
        serveOne(1'b0, 0, 0, 64'h5555_AAAA_3333_CCCC, 1'b0);
        resetMidTxn(1'b1);
        applyStimulus(1'b0, 1'b0, 3'b110, 64'h8000_000C, 64'd0);
        serveOne(1'b0, 0, 0, 64'h5555_AAAA_3333_CCCC, 1'b0);

        $display("[TB] randomized traffic");
        for (int t = 0; t < 60; t++) begin
            ri = bit'($urandom_range(0, 1));
            rm = bit'($urandom_range(0, 1));
            if (!ri && !rm) rm = 1'b1;
            wr = bit'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 7) != 0) a = a - (a % 64'(accBytes(op)));
            ia = {$urandom, $urandom};
            if ($urandom_range(0, 7) != 0) ia = ia - (ia % 64'd4);
            if (rm) applyStimulus(1'b1, wr, op, a, {$urandom, $urandom});
            if (ri) applyStimulus(1'b0, 1'b0, 3'b110, ia, 64'd0);
            first = pickMem(ri, rm);
            serveOne(first, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                     {$urandom, $urandom}, $urandom_range(0, 7) == 0);
            if (ri && rm)
                serveOne(!first, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                         {$urandom, $urandom}, $urandom_range(0, 7) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
